reg_file_flags: RTL and testbench

REG_FILE_FLAGS -- requirements
Module: reg_file_flags

---
 rtl/reg_file_flags_if.sv | 38 +++
 rtl/reg_file_flags.sv | 94 +++++++++
 tb/tb_reg_file_flags.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_flags_if.sv
// reg_file_flags_if
//   Bundles the register-file read/write ports and the ALU flag ports of
//   reg_file_flags so the datapath side and the register file share a single
//   connection.
//   master : ALU/datapath side. It drives the addresses, the write data and
//            the flag inputs, and it receives the read data and flag state.
//   slave  : register-file side, which is the mirror of master.
interface reg_file_flags_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              flag_en;
  logic              alu_zero;
  logic              alu_overflow;
  logic              flag_clr;
  logic              flag_zero;
  logic              flag_overflow;
  logic              ovf_sticky;

  modport master (
    output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data,
           flag_en, alu_zero, alu_overflow, flag_clr,
    input  rd_data_a, rd_data_b, flag_zero, flag_overflow, ovf_sticky
  );

  modport slave (
    input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data,
           flag_en, alu_zero, alu_overflow, flag_clr,
    output rd_data_a, rd_data_b, flag_zero, flag_overflow, ovf_sticky
  );
endinterface

// File: rtl/reg_file_flags.sv
// reg_file_flags
//   Register file with 2**ADDR_W entries. It has two combinational read ports
//   and one write port. Register 0 is hard-wired to zero. A write is visible
//   on a read port in the same cycle (write-through bypass). The block also
//   holds the ALU flag registers: the zero flag, the overflow flag, and a
//   sticky overflow flag that stays set until it is cleared.
// Ports
//   clk   : single clock; all state updates on its rising edge
//   rst_n : asynchronous active-low reset; clears all registers and flags
//   bus   : reg_file_flags_if.slave, which carries the read/write ports and
//           the flag ports
module reg_file_flags #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  reg_file_flags_if.slave bus
);
  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [NREG];
  logic              r_flag_zero;
  logic              r_flag_overflow;
  logic              r_ovf_sticky;

  logic              w_wr_live;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;

  // A write counts only when it targets a real register and the block is
  // out of reset. The bypass uses the same qualifier, so the bypass is off
  // while reset is held.
  assign w_wr_live = rst_n && bus.wr_en && (bus.wr_addr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_live) begin
      r_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag_zero     <= 1'b0;
      r_flag_overflow <= 1'b0;
      r_ovf_sticky    <= 1'b0;
    end else begin
      if (bus.flag_en) begin
        r_flag_zero     <= bus.alu_zero;
        r_flag_overflow <= bus.alu_overflow;
      end
      // A new overflow takes priority over a clear in the same cycle.
      if (bus.flag_en && bus.alu_overflow) begin
        r_ovf_sticky <= 1'b1;
      end else if (bus.flag_clr) begin
        r_ovf_sticky <= 1'b0;
      end
    end
  end

  // Address 0 always reads as zero, even if the stored entry were corrupted,
  // and the bypass never applies to it.
  always_comb begin
    w_rd_a = '0;
    if (!rst_n || bus.rd_addr_a == '0) begin
      w_rd_a = '0;
    end else if (w_wr_live && bus.wr_addr == bus.rd_addr_a) begin
      w_rd_a = bus.wr_data;
    end else begin
      w_rd_a = r_mem[bus.rd_addr_a];
    end
  end

  always_comb begin
    w_rd_b = '0;
    if (!rst_n || bus.rd_addr_b == '0) begin
      w_rd_b = '0;
    end else if (w_wr_live && bus.wr_addr == bus.rd_addr_b) begin
      w_rd_b = bus.wr_data;
    end else begin
      w_rd_b = r_mem[bus.rd_addr_b];
    end
  end

  assign bus.rd_data_a     = w_rd_a;
  assign bus.rd_data_b     = w_rd_b;
  assign bus.flag_zero     = r_flag_zero;
  assign bus.flag_overflow = r_flag_overflow;
  assign bus.ovf_sticky    = r_ovf_sticky;
endmodule

// File: tb/tb_reg_file_flags.sv
module tb_reg_file_flags;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;

  logic clk;
  logic rst_n;

  reg_file_flags_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  reg_file_flags #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Reference model: the architectural register contents and flags.
  logic [DATA_W-1:0] mdl_mem [32];
  logic              mdl_fz;
  logic              mdl_fo;
  logic              mdl_st;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                     input logic [DATA_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] exp_rd(input logic [ADDR_W-1:0] a);
    if (a == 0 || !rst_n) return '0;
    if (bus.wr_en && bus.wr_addr == a && bus.wr_addr != 0) return bus.wr_data;
    return mdl_mem[a];
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < 32; i++) mdl_mem[i] = '0;
    mdl_fz = 1'b0;
    mdl_fo = 1'b0;
    mdl_st = 1'b0;
  endtask

  task automatic idle();
    bus.rd_addr_a    = '0;
    bus.rd_addr_b    = '0;
    bus.wr_en        = 1'b0;
    bus.wr_addr      = '0;
    bus.wr_data      = '0;
    bus.flag_en      = 1'b0;
    bus.alu_zero     = 1'b0;
    bus.alu_overflow = 1'b0;
    bus.flag_clr     = 1'b0;
  endtask

  task automatic check_reads(input string tag);
    chk({tag, "_rda"}, bus.rd_data_a, exp_rd(bus.rd_addr_a));
    chk({tag, "_rdb"}, bus.rd_data_b, exp_rd(bus.rd_addr_b));
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_fz"}, {63'd0, bus.flag_zero}, {63'd0, mdl_fz});
    chk({tag, "_fo"}, {63'd0, bus.flag_overflow}, {63'd0, mdl_fo});
    chk({tag, "_st"}, {63'd0, bus.ovf_sticky}, {63'd0, mdl_st});
  endtask

  // Advance one rising edge, apply the spec rules to the model with the
  // inputs that were present at the edge, then check the state after the edge.
  task automatic step(input string tag);
    @(posedge clk);
    if (rst_n) begin
      if (bus.wr_en && bus.wr_addr != 0) mdl_mem[bus.wr_addr] = bus.wr_data;
      if (bus.flag_en) begin
        mdl_fz = bus.alu_zero;
        mdl_fo = bus.alu_overflow;
      end
      if (bus.flag_en && bus.alu_overflow) mdl_st = 1'b1;
      else if (bus.flag_clr) mdl_st = 1'b0;
    end
    #1;
    check_flags(tag);
    check_reads(tag);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    idle();
    mdl_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Reset state: every address on both ports reads 0 and all flags are 0.
    check_flags("rst");
    for (int i = 0; i < 32; i++) begin
      bus.rd_addr_a = ADDR_W'(i);
      bus.rd_addr_b = ADDR_W'(31 - i);
      #1;
      chk("rst_rda", bus.rd_data_a, '0);
      chk("rst_rdb", bus.rd_data_b, '0);
    end

    // Write DEAD_BEEF to r5, then read it back on both ports.
    @(negedge clk);
    idle();
    bus.wr_en = 1'b1; bus.wr_addr = 5; bus.wr_data = 64'h0000_0000_DEAD_BEEF;
    step("w5");
    @(negedge clk);
    idle();
    bus.rd_addr_a = 5; bus.rd_addr_b = 5;
    #1;
    chk("r5_a", bus.rd_data_a, 64'h0000_0000_DEAD_BEEF);
    chk("r5_b", bus.rd_data_b, 64'h0000_0000_DEAD_BEEF);

    // Bypass on port B, then the stored value after the edge.
    @(negedge clk);
    idle();
    bus.wr_en = 1'b1; bus.wr_addr = 7; bus.wr_data = 64'h1234; bus.rd_addr_b = 7;
    #1;
    chk("byp7_b", bus.rd_data_b, 64'h1234);
    step("w7");
    @(negedge clk);
    idle();
    bus.rd_addr_b = 7;
    #1;
    chk("mem7_b", bus.rd_data_b, 64'h1234);

    // A write to r0 is discarded and is never bypassed.
    @(negedge clk);
    idle();
    bus.wr_en = 1'b1; bus.wr_addr = 0; bus.wr_data = '1; bus.rd_addr_a = 0;
    #1;
    chk("r0_same", bus.rd_data_a, '0);
    step("w0");
    chk("r0_after", bus.rd_data_a, '0);

    // Flag sequence, including the case where a set and a clear collide.
    @(negedge clk);
    idle();
    bus.flag_en = 1; bus.alu_overflow = 1; bus.alu_zero = 0;
    step("fl1");
    chk("fl1_fo_c", {63'd0, bus.flag_overflow}, 64'd1);
    chk("fl1_st_c", {63'd0, bus.ovf_sticky}, 64'd1);
    @(negedge clk);
    bus.flag_en = 1; bus.alu_overflow = 0; bus.alu_zero = 1;
    step("fl2");
    chk("fl2_fz_c", {63'd0, bus.flag_zero}, 64'd1);
    chk("fl2_st_c", {63'd0, bus.ovf_sticky}, 64'd1);
    @(negedge clk);
    bus.flag_en = 1; bus.alu_overflow = 1; bus.alu_zero = 0; bus.flag_clr = 1;
    step("fl3");
    chk("fl3_st_c", {63'd0, bus.ovf_sticky}, 64'd1);
    @(negedge clk);
    idle();
    bus.flag_clr = 1;
    step("fl4");
    chk("fl4_st_c", {63'd0, bus.ovf_sticky}, 64'd0);
    chk("fl4_fo_c", {63'd0, bus.flag_overflow}, 64'd1);

    // Async reset between edges clears r3 and the flags immediately.
    @(negedge clk);
    idle();
    bus.wr_en = 1; bus.wr_addr = 3; bus.wr_data = 64'hABCD;
    bus.flag_en = 1; bus.alu_zero = 1; bus.alu_overflow = 1;
    step("w3");
    @(negedge clk);
    idle();
    bus.rd_addr_a = 3;
    #2;
    rst_n = 1'b0;
    mdl_reset();
    #1;
    chk("ar_r3", bus.rd_data_a, '0);
    check_flags("ar");
    // While reset is held, the write is ignored and the bypass is off.
    bus.wr_en = 1; bus.wr_addr = 3; bus.wr_data = 64'h5555; bus.rd_addr_b = 3;
    bus.flag_en = 1; bus.alu_overflow = 1;
    #1;
    chk("ar_byp", bus.rd_data_b, '0);
    step("ar_hold");
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    bus.rd_addr_a = 3;
    #1;
    chk("ar_r3_rel", bus.rd_data_a, '0);
    @(negedge clk);
    bus.wr_en = 1; bus.wr_addr = 3; bus.wr_data = 64'h77;
    step("first_wr");
    @(negedge clk);
    idle();
    bus.rd_addr_a = 3;
    #1;
    chk("first_wr_r3", bus.rd_data_a, 64'h77);

    // Randomized traffic checked against the model.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      bus.wr_en        = ($urandom_range(0, 3) != 0);
      bus.wr_addr      = ($urandom_range(0, 7) == 0) ? '0 : ADDR_W'($urandom_range(0, 31));
      bus.wr_data      = {$urandom, $urandom};
      bus.rd_addr_a    = ($urandom_range(0, 2) == 0) ? bus.wr_addr : ADDR_W'($urandom_range(0, 31));
      bus.rd_addr_b    = ($urandom_range(0, 2) == 0) ? bus.wr_addr : ADDR_W'($urandom_range(0, 31));
      bus.flag_en      = $urandom_range(0, 1) != 0;
      bus.alu_zero     = $urandom_range(0, 1) != 0;
      bus.alu_overflow = ($urandom_range(0, 3) == 0);
      bus.flag_clr     = ($urandom_range(0, 3) == 0);
      #1;
      check_reads("rnd_pre");
      step("rnd");
    end

    // Final sweep of the whole register file against the model.
    @(negedge clk);
    idle();
    for (int i = 0; i < 32; i++) begin
      bus.rd_addr_a = ADDR_W'(i);
      bus.rd_addr_b = ADDR_W'(i);
      #1;
      chk("sweep_a", bus.rd_data_a, mdl_mem[i]);
      chk("sweep_b", bus.rd_data_b, (i == 0) ? '0 : mdl_mem[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
